// File: rtl/bitonic_sort_sequencer.sv
// Bitonic sort sequencer: buffers a burst of N words, walks the bitonic network one
// compare-exchange at a time through an external CAS node, then streams the result.
module bitonic_sort_sequencer #(
  parameter int W       = 32,
  parameter int LOG_N   = 3,
  parameter int CAS_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         sort_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         sort_done,
  output logic [W-1:0] cas_a,
  output logic [W-1:0] cas_b,
  output logic         cas_dir,
  output logic         cas_en,
  input  logic [W-1:0] cas_o1,
  input  logic [W-1:0] cas_o2
);

  localparam int N    = 1 << LOG_N;
  localparam int CW   = LOG_N + 1;
  localparam int PH_W = $clog2(CAS_LAT + 1);

  localparam logic [CW-1:0]   N_C       = CW'(N);
  localparam logic [CW-1:0]   LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(N / 2 - 1);
  localparam logic [PH_W-1:0] PH_WB     = PH_W'(CAS_LAT);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   j_q, j_d;
  logic [CW-1:0]   p_q, p_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            dir_q, dir_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            sort_done_q, sort_done_d;

  logic [W-1:0]    mem_q [N];

  logic [CW-1:0]    msk;
  logic [LOG_N-1:0] i_c, l_c;
  logic [LOG_N-1:0] wr_idx, rd_idx, rd_nxt_idx;
  logic             eff_dir;
  logic             in_sort, load_we, wb_we;

  // Pair p of stage j maps to i by inserting a zero at bit log2(j); the partner is i|j.
  assign msk        = j_q - CW'(1);
  assign i_c        = LOG_N'(((p_q & ~msk) << 1) | (p_q & msk));
  assign l_c        = i_c | j_q[LOG_N-1:0];
  assign eff_dir    = ((({1'b0, i_c}) & k_q) != '0) ^ dir_q;
  assign wr_idx     = wr_q[LOG_N-1:0];
  assign rd_idx     = rd_q[LOG_N-1:0];
  assign rd_nxt_idx = rd_q[LOG_N-1:0] + LOG_N'(1);

  assign in_sort  = (state_q == S_SORT);
  assign load_we  = (state_q == S_LOAD) && in_valid;
  assign wb_we    = in_sort && (ph_q == PH_WB);

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign cas_en    = in_sort && (ph_q != PH_WB);
  assign cas_a     = in_sort ? mem_q[i_c] : '0;
  assign cas_b     = in_sort ? mem_q[l_c] : '0;
  assign cas_dir   = in_sort ? eff_dir : 1'b0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sort_done = sort_done_q;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    k_d         = k_q;
    j_d         = j_q;
    p_d         = p_q;
    ph_d        = ph_q;
    dir_d       = dir_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sort_done_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (wr_q == LAST_IDX) begin
            wr_d    = '0;
            dir_d   = sort_dir;
            k_d     = CW'(2);
            j_d     = CW'(1);
            p_d     = '0;
            ph_d    = '0;
            state_d = S_SORT;
          end else begin
            wr_d = wr_q + CW'(1);
          end
        end
      end
      S_SORT: begin
        if (ph_q != PH_WB) begin
          ph_d = ph_q + PH_W'(1);
        end else begin
          ph_d = '0;
          if (p_q != HALF_LAST) begin
            p_d = p_q + CW'(1);
          end else begin
            p_d = '0;
            if (j_q != CW'(1)) begin
              j_d = j_q >> 1;
            end else if (k_q != N_C) begin
              k_d = k_q << 1;
              j_d = k_q;
            end else begin
              state_d     = S_DRAIN;
              sort_done_d = 1'b1;
              rd_d        = '0;
              out_valid_d = 1'b0;
            end
          end
        end
      end
      S_DRAIN: begin
        // The register is refilled directly on each handshake so words stream back to back.
        if (out_valid_q && out_ready) begin
          if (rd_q == LAST_IDX) begin
            rd_d        = '0;
            out_valid_d = 1'b0;
            state_d     = S_LOAD;
          end else begin
            rd_d        = rd_q + CW'(1);
            out_data_d  = mem_q[rd_nxt_idx];
            out_valid_d = 1'b1;
          end
        end else if (!out_valid_q) begin
          out_data_d  = mem_q[rd_idx];
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      wr_q        <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      j_q         <= '0;
      p_q         <= '0;
      ph_q        <= '0;
      dir_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sort_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      k_q         <= k_d;
      j_q         <= j_d;
      p_q         <= p_d;
      ph_q        <= ph_d;
      dir_q       <= dir_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sort_done_q <= sort_done_d;
    end
  end

  // Burst storage carries no reset; its contents are meaningless outside a burst.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[wr_idx] <= in_data;
    if (wb_we) begin
      mem_q[i_c] <= cas_o1;
      mem_q[l_c] <= cas_o2;
    end
  end

endmodule

// File: tb/tb_bitonic_sort_sequencer.sv
// Directed bench for bitonic_sort_sequencer with a registered CAS node model.
module tb_bitonic_sort_sequencer;

  localparam int W       = 32;
  localparam int LOG_N   = 3;
  localparam int CAS_LAT = 2;
  localparam int N       = 8;

  typedef logic [W-1:0] word_t;

  logic  clk = 1'b0, rst = 1'b1;
  logic  in_valid = 1'b0, in_ready, sort_dir = 1'b0;
  word_t in_data = '0;
  logic  out_valid, out_ready = 1'b0;
  word_t out_data;
  logic  busy, sort_done, cas_dir, cas_en;
  word_t cas_a, cas_b;
  word_t cm_o1 = '0, cm_o2 = '0;
  int    cm_cnt = 0;

  int checks = 0, errors = 0;

  int    wins = 0, run = 0, bad_len = 0, unstable = 0;
  logic  prev_en = 1'b0;
  word_t a0 = '0, b0 = '0;
  logic  d0 = 1'b0;
  int    acc = 0, acc_busy = 0, hs = 0;

  bitonic_sort_sequencer #(.W(W), .LOG_N(LOG_N), .CAS_LAT(CAS_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sort_dir(sort_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .sort_done(sort_done),
    .cas_a(cas_a), .cas_b(cas_b), .cas_dir(cas_dir), .cas_en(cas_en),
    .cas_o1(cm_o1), .cas_o2(cm_o2)
  );

  always #5 clk = ~clk;

  // CAS node: result appears only after CAS_LAT enabled cycles, poison before that.
  always @(posedge clk) begin
    if (cas_en) begin
      cm_cnt <= cm_cnt + 1;
      if (cm_cnt == CAS_LAT - 1) begin
        if (!cas_dir) begin
          cm_o1 <= (cas_a < cas_b) ? cas_a : cas_b;
          cm_o2 <= (cas_a < cas_b) ? cas_b : cas_a;
        end else begin
          cm_o1 <= (cas_a < cas_b) ? cas_b : cas_a;
          cm_o2 <= (cas_a < cas_b) ? cas_a : cas_b;
        end
      end else begin
        cm_o1 <= 32'hDEAD0BAD;
        cm_o2 <= 32'hBAD0DEAD;
      end
    end else begin
      cm_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      run     <= 0;
      prev_en <= 1'b0;
    end else begin
      prev_en <= cas_en;
      if (cas_en) begin
        run <= run + 1;
        if (!prev_en) begin
          wins <= wins + 1;
          a0   <= cas_a;
          b0   <= cas_b;
          d0   <= cas_dir;
        end else if (cas_a !== a0 || cas_b !== b0 || cas_dir !== d0) begin
          unstable <= unstable + 1;
        end
      end else begin
        run <= 0;
        if (prev_en && run != CAS_LAT) bad_len <= bad_len + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc <= acc + 1;
    if (!rst && in_valid && in_ready && busy) acc_busy <= acc_busy + 1;
    if (!rst && out_valid && out_ready) hs <= hs + 1;
  end

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic load_burst(input word_t d[N], input logic dir, input bit gaps, input bit hold);
    for (int n = 0; n < N; n++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          in_valid = 1'b0;
          in_data  = $urandom;
          @(posedge clk); @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = d[n];
      sort_dir = (n == N - 1) ? dir : ~dir;
      chkb("load_ready", in_ready, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    in_data  = 32'h1234_5678;
    in_valid = hold;
    sort_dir = ~dir;
  endtask

  task automatic wait_sort(input int win_base);
    int n = 0;
    while (sort_done !== 1'b1 && n < 300) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("sort_cycles", n, 72);
    chk("sort_windows", wins - win_base, 24);
    chkb("busy_at_done", busy, 1'b1);
    chkb("in_ready_at_done", in_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    chkb("sort_done_pulse", sort_done, 1'b0);
  endtask

  task automatic drain(input word_t e[N], input bit stall);
    int to;
    for (int n = 0; n < N; n++) begin
      to = 0;
      while (out_valid !== 1'b1 && to < 10) begin
        @(posedge clk); @(negedge clk);
        to++;
      end
      chkb("drain_valid", out_valid, 1'b1);
      if (stall) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); @(negedge clk);
          chk("stall_hold", out_data, e[n]);
          chkb("stall_in_ready", in_ready, 1'b0);
        end
      end
      chk("drain_data", out_data, e[n]);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chkb("end_out_valid", out_valid, 1'b0);
    chkb("end_busy", busy, 1'b0);
    chkb("end_in_ready", in_ready, 1'b1);
  endtask

  word_t vec_a[N]    = '{32'd5, 32'd3, 32'd7, 32'd0, 32'd6, 32'd1, 32'd4, 32'd2};
  word_t exp_asc[N]  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
  word_t exp_desc[N] = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  word_t vec_d[N]    = '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd1, 32'h80000000, 32'd2};
  word_t exp_d_a[N]  = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  word_t exp_d_d[N]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};

  initial begin
    int wb, ab, hb, n, g;
    logic prev;

    // Reset values
    @(negedge clk);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_sort_done", sort_done, 1'b0);
    chkb("rst_cas_en", cas_en, 1'b0);
    chk("rst_cas_a", cas_a, 32'd0);
    chk("rst_cas_b", cas_b, 32'd0);
    chkb("rst_cas_dir", cas_dir, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b1);

    // Ascending sort
    wb = wins; ab = acc; hb = hs;
    load_burst(vec_a, 1'b0, 1'b0, 1'b0);
    wait_sort(wb);
    drain(exp_asc, 1'b0);
    chk("asc_accepts", acc - ab, 8);
    chk("asc_handshakes", hs - hb, 8);

    // Descending sort with backpressure
    wb = wins; ab = acc; hb = hs;
    load_burst(vec_a, 1'b1, 1'b0, 1'b0);
    wait_sort(wb);
    drain(exp_desc, 1'b1);
    chk("desc_handshakes", hs - hb, 8);

    // Duplicates/extremes, input gaps, in_valid held high while busy
    wb = wins; ab = acc; hb = hs;
    load_burst(vec_d, 1'b0, 1'b1, 1'b1);
    wait_sort(wb);
    drain(exp_d_a, 1'b0);
    chk("dup_accepts", acc - ab, 8);
    chk("dup_handshakes", hs - hb, 8);
    chk("accepts_while_busy", acc_busy, 0);

    // Reset during the 10th compare
    load_burst(vec_a, 1'b0, 1'b0, 1'b0);
    prev = 1'b0; n = 0; g = 0;
    while (g < 400) begin
      if (cas_en === 1'b1 && !prev) n++;
      prev = cas_en;
      if (n == 10) break;
      @(posedge clk); @(negedge clk);
      g++;
    end
    chk("rst_reach_10th", n, 10);
    chkb("cas_en_before_rst", cas_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    chkb("midrst_cas_en", cas_en, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chk("midrst_cas_a", cas_a, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkb("postrst_in_ready", in_ready, 1'b1);
    chkb("postrst_out_valid", out_valid, 1'b0);

    // Fresh burst after reset
    wb = wins; ab = acc; hb = hs;
    load_burst(vec_d, 1'b1, 1'b0, 1'b0);
    wait_sort(wb);
    drain(exp_d_d, 1'b0);
    chk("fresh_accepts", acc - ab, 8);
    chk("fresh_handshakes", hs - hb, 8);

    chk("cas_window_len_errs", bad_len, 0);
    chk("cas_unstable_errs", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
